// File: rtl/timer_pkg.sv
// Shared constants and state type for the programmable pulse timer.
package timer_pkg;

  localparam logic MODE_ASTABLE = 1'b0;
  localparam logic MODE_MONO    = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/phase_down_counter.sv
// Loadable down-counter timing one HIGH or LOW phase; counts down to 1.
module phase_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: a load wins over decrement, and a zero length loads as one.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_val == '0) ? ONE : load_val;
    end else if (dec && (count_q > ONE)) begin
      count_d = count_q - ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == ONE);

endmodule

// File: rtl/prog_pulse_timer.sv
// Programmable astable / monostable pulse timer with done strobe and period counter.
module prog_pulse_timer #(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 8,
  parameter int RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             trigger,
  input  logic [WIDTH-1:0] on_len,
  input  logic [WIDTH-1:0] off_len,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_cnt
);

  import timer_pkg::*;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic             trig_q;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             trig_rise;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             dec;
  logic             last;

  assign trig_rise = trigger & ~trig_q;

  phase_down_counter #(
    .WIDTH (WIDTH)
  ) u_phase (
    .clk      (clk),
    .rst_n    (reset),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .last     (last)
  );

  // Next-state, counter control and registered-output decode.
  always_comb begin
    state_d = state_q;
    mode_d  = (state_q == IDLE) ? mode : mode_q;
    ld      = 1'b0;
    ld_val  = on_len;
    dec     = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (enable && ((mode == MODE_ASTABLE) || trig_rise)) begin
          state_d = HIGH;
          ld      = 1'b1;
          ld_val  = on_len;
        end
      end
      HIGH: begin
        // Abort outranks retrigger, which outranks the end of the phase.
        if (!enable) begin
          state_d = IDLE;
        end else if ((RETRIGGER != 0) && (mode_q == MODE_MONO) && trig_rise) begin
          ld     = 1'b1;
          ld_val = on_len;
        end else if (last) begin
          if (mode_q == MODE_MONO) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = LOW;
            ld      = 1'b1;
            ld_val  = off_len;
          end
        end else begin
          dec = 1'b1;
        end
      end
      LOW: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = HIGH;
          ld      = 1'b1;
          ld_val  = on_len;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pulse_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  // State, latched mode, trigger history and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_ASTABLE;
      trig_q  <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      trig_q  <= trigger;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse      = pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign period_cnt = cnt_q;

endmodule

// File: tb/tb_prog_pulse_timer.sv
// Randomised and directed bench for prog_pulse_timer against a phase-remaining model.
module tb_prog_pulse_timer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         mode;
  logic         trigger;
  logic [W-1:0] on_len;
  logic [W-1:0] off_len;

  logic       pulse_a, busy_a, done_a;
  logic [7:0] cnt_a;
  logic       pulse_r, busy_r, done_r;
  logic [7:0] cnt_r;
  logic       pulse_w, busy_w, done_w;
  logic [1:0] cnt_w;

  prog_pulse_timer #(.WIDTH(W), .CNT_W(8), .RETRIGGER(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .trigger(trigger),
    .on_len(on_len), .off_len(off_len),
    .pulse(pulse_a), .busy(busy_a), .done(done_a), .period_cnt(cnt_a));

  prog_pulse_timer #(.WIDTH(W), .CNT_W(8), .RETRIGGER(1)) dut_r (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .trigger(trigger),
    .on_len(on_len), .off_len(off_len),
    .pulse(pulse_r), .busy(busy_r), .done(done_r), .period_cnt(cnt_r));

  prog_pulse_timer #(.WIDTH(W), .CNT_W(2), .RETRIGGER(0)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .trigger(trigger),
    .on_len(on_len), .off_len(off_len),
    .pulse(pulse_w), .busy(busy_w), .done(done_w), .period_cnt(cnt_w));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: per instance, whether running, whether in the high phase, cycles left in phase.
  int m_busy[3], m_high[3], m_rem[3], m_mono[3], m_cnt[3], m_done[3], m_prev[3];
  int m_retrig[3] = '{0, 1, 0};
  int m_mod[3]    = '{256, 256, 4};

  function automatic int len1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_high[i] = 0; m_rem[i] = 0; m_mono[i] = 0;
      m_cnt[i] = 0; m_done[i] = 0; m_prev[i] = 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs present before it.
  task automatic model_step();
    int rise;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      rise = (trigger && (m_prev[i] == 0)) ? 1 : 0;
      m_prev[i] = trigger ? 1 : 0;
      m_done[i] = 0;
      if (m_busy[i] == 0) begin
        if (enable && (!mode || rise == 1)) begin
          m_busy[i] = 1; m_high[i] = 1; m_mono[i] = mode ? 1 : 0;
          m_rem[i] = len1(int'(on_len));
        end
      end else if (!enable) begin
        m_busy[i] = 0; m_high[i] = 0;
      end else if (m_retrig[i] == 1 && m_mono[i] == 1 && m_high[i] == 1 && rise == 1) begin
        m_rem[i] = len1(int'(on_len));
      end else if (m_rem[i] > 1) begin
        m_rem[i]--;
      end else if (m_high[i] == 1 && m_mono[i] == 1) begin
        m_busy[i] = 0; m_high[i] = 0; m_done[i] = 1;
        m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
      end else if (m_high[i] == 1) begin
        m_high[i] = 0; m_rem[i] = len1(int'(off_len));
      end else begin
        m_high[i] = 1; m_rem[i] = len1(int'(on_len)); m_done[i] = 1;
        m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
      end
    end
  endtask

  task automatic check_inst(input string pfx, input int i, input logic p, input logic b,
                            input logic d, input logic [7:0] c);
    chk({pfx, ".pulse"}, 32'(p), 32'((m_busy[i] == 1) && (m_high[i] == 1)));
    chk({pfx, ".busy"},  32'(b), 32'(m_busy[i]));
    chk({pfx, ".done"},  32'(d), 32'(m_done[i]));
    chk({pfx, ".cnt"},   32'(c), 32'(m_cnt[i]));
  endtask

  task automatic check_all();
    check_inst("a", 0, pulse_a, busy_a, done_a, cnt_a);
    check_inst("r", 1, pulse_r, busy_r, done_r, cnt_r);
    check_inst("w", 2, pulse_w, busy_w, done_w, {6'd0, cnt_w});
  endtask

  int hi_a, hi_r, dn_a, dn_r, dn_w;

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    hi_a += int'(pulse_a); hi_r += int'(pulse_r);
    dn_a += int'(done_a);  dn_r += int'(done_r); dn_w += int'(done_w);
  endtask

  task automatic clear_stats();
    hi_a = 0; hi_r = 0; dn_a = 0; dn_r = 0; dn_w = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    clear_stats();
  endtask

  // Re-arm the trigger so its rising edge lands at the end of high cycle k of dut_r.
  task automatic retrig_at(input int k);
    int guard = 0;
    while (hi_r < k - 1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("retrig_reach", 32'(hi_r), 32'(k - 1));
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
  endtask

  logic [1:0] wrap_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    reset = 1'b0; enable = 1'b1; mode = 1'b0; trigger = 1'b0;
    on_len = 16'd3; off_len = 16'd5;
    model_reset();
    clear_stats();

    // Reset held with enable high keeps everything quiet.
    @(posedge clk); #1;
    check_all();
    @(posedge clk); #1;
    chk("rst.pulse", 32'(pulse_a), 32'd0);
    chk("rst.busy",  32'(busy_a),  32'd0);
    chk("rst.cnt",   32'(cnt_a),   32'd0);
    reset = 1'b1;

    // Astable 3 high / 5 low.
    tick();
    chk("ast.first_pulse", 32'(pulse_a), 32'd1);
    for (int i = 0; i < 32; i++) tick();
    chk("ast.cnt_after_33", 32'(cnt_a), 32'd4);
    chk("ast.done_count", 32'(dn_a), 32'd4);
    chk("ast.high_cycles", 32'(hi_a), 32'd12 + 32'd1);
    for (int i = 0; i < 7; i++) tick();

    // Zero lengths give a 1/1 toggle.
    do_reset();
    on_len = '0; off_len = '0;
    for (int i = 0; i < 12; i++) tick();
    chk("zero.done_count", 32'(dn_a), 32'd5);
    chk("zero.high_cycles", 32'(hi_a), 32'd6);

    // Monostable, second edge at pulse cycle 4, trigger then held high.
    do_reset();
    mode = 1'b1; on_len = 16'd10; off_len = 16'd7;
    tick();
    trigger = 1'b1;
    retrig_at(4);
    for (int i = 0; i < 30; i++) tick();
    chk("mono.high", 32'(hi_a), 32'd10);
    chk("mono.done", 32'(dn_a), 32'd1);
    chk("mono.cnt",  32'(cnt_a), 32'd1);
    chk("mono_rt4.high", 32'(hi_r), 32'd14);

    // Retrigger at pulse cycle 6 stretches to 16 with a single done.
    do_reset();
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    retrig_at(6);
    for (int i = 0; i < 25; i++) tick();
    chk("rt6.high", 32'(hi_r), 32'd16);
    chk("rt6.done", 32'(dn_r), 32'd1);
    chk("rt6.norm_high", 32'(hi_a), 32'd10);

    // Abort mid-HIGH, then five periods on the 2-bit counter.
    do_reset();
    trigger = 1'b0; mode = 1'b0; on_len = 16'd2; off_len = 16'd2;
    tick();
    enable = 1'b0;
    tick();
    chk("abort.pulse", 32'(pulse_w), 32'd0);
    chk("abort.busy",  32'(busy_w),  32'd0);
    chk("abort.done",  32'(done_w),  32'd0);
    enable = 1'b1;
    dn_w = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (done_w && dn_w >= 1 && dn_w <= 5) chk("wrap.seq", 32'(cnt_w), 32'(wrap_seq[dn_w - 1]));
    end
    chk("wrap.done_count", 32'(dn_w), 32'd5);
    chk("wrap.final", 32'(cnt_w), 32'd1);

    // Random stimulus.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(23) != 0);
      if ($urandom_range(39) == 0) mode = ~mode;
      if ($urandom_range(3) == 0) trigger = ~trigger;
      if ($urandom_range(9) == 0) on_len = W'($urandom_range(6));
      if ($urandom_range(9) == 0) off_len = W'($urandom_range(6));
      if ($urandom_range(299) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_pulse_timer.md
Name: prog_pulse_timer

Overview:
Parametrised successor to the fixed-constant 555-style timer. Run-time programmable high and low durations in clock cycles. Two modes: astable (free-running square/PWM) and monostable (one-shot on trigger, optional retrigger). Adds a completion strobe and a period counter. Sits beside other lab peripherals as a pulse/PWM source, driven from switches or a control FSM.

Parameters:
WIDTH, 16, bit width of the duration inputs and internal phase counter
CNT_W, 8, bit width of the completed-period counter
RETRIGGER, 0, 1 = a trigger during a monostable HIGH phase reloads the HIGH count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  level; 1 = run, 0 = abort to IDLE
mode  input  1  0 = astable, 1 = monostable; sampled only in IDLE
trigger  input  1  monostable start; rising edge detected internally
on_len  input  WIDTH  HIGH-phase length in cycles; 0 treated as 1
off_len  input  WIDTH  LOW-phase length in cycles; 0 treated as 1
pulse  output  1  timer output, registered
busy  output  1  1 when state != IDLE, registered
done  output  1  one-cycle strobe at end of period (astable) or end of pulse (monostable)
period_cnt  output  CNT_W  count of completed periods/pulses; wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): state=IDLE; pulse=0, busy=0, done=0, period_cnt=0; phase counter=0; trigger edge register=0.
- States: IDLE, HIGH, LOW. All outputs are registered and decoded from next state.
- Length latch: on_len/off_len are captured into the phase counter on entry to HIGH/LOW. Changing the inputs mid-phase has no effect until the next phase entry.
- Zero length: a value of 0 loads as 1, so every phase lasts at least 1 cycle.
- Mode latch: mode is captured on leaving IDLE and held until the next return to IDLE.
- Astable, IDLE -> HIGH: on the first edge with enable=1. pulse=1 from the next cycle for exactly on_len cycles.
- Astable, HIGH -> LOW: after on_len cycles. pulse=0 for exactly off_len cycles.
- Astable, LOW -> HIGH: after off_len cycles. In the final LOW cycle, done=1 and period_cnt increments on the same edge that re-enters HIGH. Period = on_len + off_len cycles, no gap cycles.
- Monostable, IDLE -> HIGH: on the edge where enable=1 and trigger rose (trigger=1, previous sample=0). pulse=1 for on_len cycles.
- Monostable, HIGH -> IDLE: after on_len cycles; done=1 for one cycle and period_cnt increments. The LOW phase and off_len are not used.
- Retrigger: applies only when RETRIGGER=1, mode=monostable and state=HIGH. A trigger rising edge reloads the counter with on_len, extending the pulse; no done strobe occurs for the interrupted pulse. With RETRIGGER=0, triggers during HIGH are ignored.
- Trigger level held high: produces no new pulse; a new pulse requires a fresh rising edge.
- Abort: enable=0 in any state -> IDLE on the next edge; pulse=0 and busy=0 that cycle; no done strobe; period_cnt is kept.
- Simultaneous events: abort beats phase end and trigger.
- Astable terminal cycle with enable=0: no done strobe and no increment.
- period_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-phase: immediate return to reset values. Deassertion is assumed synchronised externally.
- Counter width: the phase counter is WIDTH bits and counts down to 1, so there is no overflow. Maximum phase = 2^WIDTH-1 cycles.

Decomposition:
- Package timer_pkg: mode constants (MODE_ASTABLE=0, MODE_MONO=1) and state encoding (IDLE, HIGH, LOW as 2-bit localparams).
- One sub-module, phase_down_counter:
  - Inputs: load, load_val (zero coerced to 1), dec.
  - Output: last (count==1).
  - Parameter: WIDTH.
- The FSM, edge detector and period counter stay in the top module.

Test Plan:
- Reset check: hold reset=0 with enable=1 -> pulse=0, busy=0, done=0, period_cnt=0; release -> astable starts on the first edge.
- Astable waveform, on_len=3, off_len=5, enable=1 for 40 cycles -> repeating 3 high/5 low from cycle 1; done pulses every 8 cycles; period_cnt=4 after cycle 33.
- Zero lengths in astable, on_len=0, off_len=0 -> 1 high/1 low toggle; done every 2 cycles.
- Monostable with RETRIGGER=0, on_len=10:
  - Trigger edge -> exactly 10 high cycles, then done=1 once and period_cnt +1.
  - Second trigger edge at pulse cycle 4 is ignored.
  - Trigger held high after the pulse gives no new pulse.
- Monostable with RETRIGGER=1, on_len=10, retrigger at pulse cycle 6 -> total high = 16 cycles; a single done strobe.
- Abort and wrap, CNT_W=2:
  - enable dropped mid-HIGH -> pulse=0 next cycle, busy=0, no done.
  - Then run 5 astable periods -> period_cnt sequence 1, 2, 3, 0, 1.
